bcd_display_scanner: RTL and testbench

BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

---
 rtl/bcd_display_pkg.sv | 58 +++++
 rtl/bcd_to_7seg.sv | 16 +
 rtl/bcd_display_scanner.sv | 154 +++++++++++++++
 tb/tb_bcd_display_scanner.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_display_pkg.sv
// Shared digit geometry, scan FSM encoding and 7-segment glyph table
// for the multiplexed BCD display scanner.
package bcd_display_pkg;

   localparam int DIGIT_W = 4;
   localparam int DIGIT_N = 4;
   localparam int IDX_W   = $clog2(DIGIT_N);

   typedef logic [DIGIT_W-1:0] digit_t;
   typedef digit_t [DIGIT_N-1:0] digit_set_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } scan_state_t;

   // Segment order is {g,f,e,d,c,b,a}, 1 = lit.
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_E     = 7'h79;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   function automatic logic [6:0] glyph(input digit_t code);
      logic [6:0] g;
      case (code)
         4'd0:    g = SEG_0;
         4'd1:    g = SEG_1;
         4'd2:    g = SEG_2;
         4'd3:    g = SEG_3;
         4'd4:    g = SEG_4;
         4'd5:    g = SEG_5;
         4'd6:    g = SEG_6;
         4'd7:    g = SEG_7;
         4'd8:    g = SEG_8;
         4'd9:    g = SEG_9;
         default: g = SEG_E;
      endcase
      return g;
   endfunction

   function automatic logic any_invalid(input digit_set_t d);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DIGIT_N; i++) begin
         if (d[i] > digit_t'(9)) bad = 1'b1;
      end
      return bad;
   endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to 7-segment decoder; non-decimal codes show 'E',
// and the blank flag forces every segment off.
module bcd_to_7seg
   import bcd_display_pkg::*;
(
   input  digit_t     code,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank) seg = glyph(code);
   end

endmodule

// File: rtl/bcd_display_scanner.sv
// Four-digit multiplexed 7-segment scanner with a one-deep shadow register;
// new digit sets are only taken into the display at frame boundaries.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | nothing shown yet; waits for the first pending digit set
//   ST_SCAN | cycling digits 0..3, SCAN_DIV clocks each; reload at frame end
module bcd_display_scanner
   import bcd_display_pkg::*;
#(
   parameter int unsigned SCAN_DIV   = 1000,
   parameter bit          ACTIVE_LOW = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         bcd_valid,
   output logic         bcd_ready,
   input  logic [3:0]   bcd_0,
   input  logic [3:0]   bcd_1,
   input  logic [3:0]   bcd_2,
   input  logic [3:0]   bcd_3,
   input  logic         blank_lz,
   output logic [6:0]   seg,
   output logic         dp,
   output logic [3:0]   an,
   output logic         bcd_err
);

   localparam int                PRESC_W    = $clog2(SCAN_DIV);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGIT_N - 1);

   scan_state_t        state_q,   state_d;
   logic [IDX_W-1:0]   idx_q,     idx_d;
   logic [PRESC_W-1:0] presc_q,   presc_d;
   logic               pending_q, pending_d;
   logic               ready_q,   ready_d;
   logic               err_q,     err_d;
   digit_set_t         shadow_q,  shadow_d;
   digit_set_t         disp_q,    disp_d;
   logic [6:0]         seg_q,     seg_d;
   logic [3:0]         an_q,      an_d;

   logic               xfer;
   logic               load;
   digit_set_t         bcd_in;
   logic [DIGIT_N-1:0] lz_run;
   logic               blank_cur;
   logic [6:0]         dec_seg;

   assign bcd_in = {bcd_3, bcd_2, bcd_1, bcd_0};
   assign xfer   = bcd_valid & ready_q;

   // lz_run[k]: digit k and every higher digit are zero; digit 0 never blanks.
   always_comb begin
      lz_run = '0;
      lz_run[DIGIT_N-1] = (disp_q[DIGIT_N-1] == '0);
      for (int k = DIGIT_N - 2; k >= 1; k--) begin
         lz_run[k] = lz_run[k+1] & (disp_q[k] == '0);
      end
   end

   assign blank_cur = blank_lz & lz_run[idx_q];

   bcd_to_7seg u_dec (
      .code  (disp_q[idx_q]),
      .blank (blank_cur),
      .seg   (dec_seg)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      presc_d   = presc_q;
      pending_d = pending_q;
      shadow_d  = shadow_q;
      disp_d    = disp_q;
      err_d     = err_q;
      load      = 1'b0;

      // A transfer needs ready_q=1, i.e. pending_q=0, so it never races a load.
      if (xfer) begin
         shadow_d  = bcd_in;
         pending_d = 1'b1;
         err_d     = any_invalid(bcd_in);
      end

      case (state_q)
         ST_IDLE: begin
            if (pending_q) load = 1'b1;
         end
         ST_SCAN: begin
            if (presc_q == PRESC_LAST) begin
               presc_d = '0;
               idx_d   = idx_q + IDX_W'(1);
               if ((idx_q == IDX_LAST) && pending_q) load = 1'b1;
            end else begin
               presc_d = presc_q + PRESC_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (load) begin
         disp_d    = shadow_q;
         pending_d = 1'b0;
         state_d   = ST_SCAN;
         idx_d     = '0;
         presc_d   = '0;
      end

      ready_d = ~pending_d;

      an_d  = 4'b0000;
      seg_d = SEG_BLANK;
      if (state_q == ST_SCAN) begin
         an_d  = 4'b0001 << idx_q;
         seg_d = dec_seg;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         presc_q   <= '0;
         pending_q <= 1'b0;
         ready_q   <= 1'b1;
         err_q     <= 1'b0;
         shadow_q  <= '0;
         disp_q    <= '0;
         seg_q     <= SEG_BLANK;
         an_q      <= 4'b0000;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         presc_q   <= presc_d;
         pending_q <= pending_d;
         ready_q   <= ready_d;
         err_q     <= err_d;
         shadow_q  <= shadow_d;
         disp_q    <= disp_d;
         seg_q     <= seg_d;
         an_q      <= an_d;
      end
   end

   assign bcd_ready = ready_q;
   assign bcd_err   = err_q;
   assign seg       = seg_q ^ {7{ACTIVE_LOW}};
   assign an        = an_q ^ {4{ACTIVE_LOW}};
   assign dp        = ACTIVE_LOW;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed vector bench for bcd_display_scanner at SCAN_DIV=4, ACTIVE_LOW=0.
module tb_bcd_display_scanner;

   localparam int SD = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       bcd_valid = 1'b0;
   logic       blank_lz = 1'b0;
   logic [3:0] bcd_0 = '0, bcd_1 = '0, bcd_2 = '0, bcd_3 = '0;
   logic       bcd_ready, dp, bcd_err;
   logic [6:0] seg;
   logic [3:0] an;

   int vec_cnt = 0;
   int mis_cnt = 0;

   typedef struct packed {
      logic [15:0]      digits;
      logic             blank;
      logic [3:0][6:0]  exp;
      logic             err;
   } vec_t;

   vec_t vecs [10];

   bcd_display_scanner #(.SCAN_DIV(SD), .ACTIVE_LOW(1'b0)) dut (
      .clk       (clk),
      .reset     (reset),
      .bcd_valid (bcd_valid),
      .bcd_ready (bcd_ready),
      .bcd_0     (bcd_0),
      .bcd_1     (bcd_1),
      .bcd_2     (bcd_2),
      .bcd_3     (bcd_3),
      .blank_lz  (blank_lz),
      .seg       (seg),
      .dp        (dp),
      .an        (an),
      .bcd_err   (bcd_err)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [15:0] d, input logic b,
                               input logic [6:0] s3, input logic [6:0] s2,
                               input logic [6:0] s1, input logic [6:0] s0,
                               input logic e);
      vec_t v;
      v.digits = d;
      v.blank  = b;
      v.exp    = {s3, s2, s1, s0};
      v.err    = e;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         mis_cnt++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [15:0] d);
      {bcd_3, bcd_2, bcd_1, bcd_0} = d;
   endtask

   task automatic wait_ready(input int budget);
      int n;
      n = 0;
      while (!bcd_ready && n < budget) begin
         step();
         n++;
      end
      chk("ready_wait", 16'(bcd_ready), 16'd1);
   endtask

   // Checks one full frame starting at the first cycle of digit 0.
   task automatic check_frame(input vec_t v, input string tag);
      for (int k = 0; k < 4; k++) begin
         for (int c = 0; c < SD; c++) begin
            chk($sformatf("%s_an_d%0d_c%0d", tag, k, c), 16'(an), 16'(4'b0001 << k));
            chk($sformatf("%s_seg_d%0d_c%0d", tag, k, c), 16'(seg), 16'(v.exp[k]));
            step();
         end
      end
      chk($sformatf("%s_dp", tag), 16'(dp), 16'd0);
   endtask

   task automatic apply_vec(input vec_t v, input string tag);
      wait_ready(64);
      blank_lz = v.blank;
      drive(v.digits);
      bcd_valid = 1'b1;
      step();
      bcd_valid = 1'b0;
      chk({tag, "_err"}, 16'(bcd_err), 16'(v.err));
      chk({tag, "_ready_low"}, 16'(bcd_ready), 16'd0);
      wait_ready(64);
      step();
      check_frame(v, tag);
   endtask

   initial begin
      int lat;
      vecs[0] = mk(16'h1234, 1'b0, 7'h06, 7'h5B, 7'h4F, 7'h66, 1'b0);
      vecs[1] = mk(16'h0050, 1'b1, 7'h00, 7'h00, 7'h6D, 7'h3F, 1'b0);
      vecs[2] = mk(16'h0000, 1'b1, 7'h00, 7'h00, 7'h00, 7'h3F, 1'b0);
      vecs[3] = mk(16'h12C4, 1'b0, 7'h06, 7'h5B, 7'h79, 7'h66, 1'b1);
      vecs[4] = mk(16'h9999, 1'b0, 7'h6F, 7'h6F, 7'h6F, 7'h6F, 1'b0);
      vecs[5] = mk(16'h1111, 1'b0, 7'h06, 7'h06, 7'h06, 7'h06, 1'b0);
      vecs[6] = mk(16'h0003, 1'b0, 7'h3F, 7'h3F, 7'h3F, 7'h4F, 1'b0);
      vecs[7] = mk(16'h0708, 1'b1, 7'h00, 7'h07, 7'h3F, 7'h7F, 1'b0);
      vecs[8] = mk(16'h0600, 1'b0, 7'h3F, 7'h7D, 7'h3F, 7'h3F, 1'b0);
      vecs[9] = mk(16'hFA00, 1'b1, 7'h79, 7'h79, 7'h3F, 7'h3F, 1'b1);

      #2 reset = 1'b0;
      #1;
      chk("rst_an", 16'(an), 16'd0);
      chk("rst_seg", 16'(seg), 16'd0);
      chk("rst_dp", 16'(dp), 16'd0);
      chk("rst_ready", 16'(bcd_ready), 16'd1);
      chk("rst_err", 16'(bcd_err), 16'd0);
      step();
      step();
      reset = 1'b1;
      step();
      chk("idle_an", 16'(an), 16'd0);

      for (int i = 0; i < 6; i++) apply_vec(vecs[i], $sformatf("v%0d", i));

      // Mid-frame transfer with valid held and data churning afterwards.
      for (int i = 0; i < 5; i++) step();
      blank_lz = 1'b0;
      drive(16'h9999);
      bcd_valid = 1'b1;
      step();
      chk("mid_ready_low", 16'(bcd_ready), 16'd0);
      chk("mid_err", 16'(bcd_err), 16'd0);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         drive({4{4'(i % 9)}});
         step();
         if (bcd_ready) begin
            lat = i;
            break;
         end
         chk($sformatf("mid_old_seg_%0d", i), 16'(seg), 16'h06);
         chk($sformatf("mid_old_an_%0d", i), 16'(an), 16'(4'b0001 << ((6 + i) / 4)));
      end
      bcd_valid = 1'b0;
      chk("mid_ready_latency", 16'(lat), 16'd9);
      chk("mid_last_an", 16'(an), 16'h8);
      chk("mid_last_seg", 16'(seg), 16'h06);
      step();
      check_frame(vecs[4], "mid_new");

      // Reset during digit 2 with a set pending in the shadow.
      for (int i = 0; i < 8; i++) step();
      chk("rb_an_d2", 16'(an), 16'h4);
      drive(16'h555C);
      bcd_valid = 1'b1;
      step();
      bcd_valid = 1'b0;
      chk("rb_err_set", 16'(bcd_err), 16'd1);
      chk("rb_pending", 16'(bcd_ready), 16'd0);
      #1 reset = 1'b0;
      #1;
      chk("rb_an", 16'(an), 16'd0);
      chk("rb_seg", 16'(seg), 16'd0);
      chk("rb_dp", 16'(dp), 16'd0);
      chk("rb_ready", 16'(bcd_ready), 16'd1);
      chk("rb_err", 16'(bcd_err), 16'd0);
      step();
      step();
      reset = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         chk($sformatf("rb_idle_an_%0d", i), 16'(an), 16'd0);
         chk($sformatf("rb_idle_ready_%0d", i), 16'(bcd_ready), 16'd1);
      end

      for (int i = 6; i < 10; i++) apply_vec(vecs[i], $sformatf("v%0d", i));

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
